boreal_symbolic_fsm: RTL and testbench



---
 rtl/boreal_symbolic_fsm_if.sv | 32 +++
 rtl/boreal_symbolic_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_boreal_symbolic_fsm.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boreal_symbolic_fsm_if.sv
// Sample/result bundle for the symbolic intent classifier.
// The master side drives samples and thresholds; the slave side (the
// classifier) returns one result strobe per accepted sample.
interface boreal_symbolic_fsm_if #(
  parameter int W = 24
);
  // Sample side
  logic                valid_in;
  logic signed [W-1:0] intent_x;
  logic signed [W-1:0] intent_y;
  // Threshold side (unsigned, may change at any time)
  logic [W-1:0]        thresh_move;
  logic [W-1:0]        thresh_hold;
  logic [W:0]          thresh_select;
  // Result side
  logic                valid_out;
  logic [2:0]          state_id;
  logic                change_pulse;
  logic                select_event;

  modport master (
    output valid_in, intent_x, intent_y,
    output thresh_move, thresh_hold, thresh_select,
    input  valid_out, state_id, change_pulse, select_event
  );

  modport slave (
    input  valid_in, intent_x, intent_y,
    input  thresh_move, thresh_hold, thresh_select,
    output valid_out, state_id, change_pulse, select_event
  );
endinterface

// File: rtl/boreal_symbolic_fsm.sv
// Continuous-to-symbolic intent classifier.
// Stage 1 turns each signed (x, y) sample into magnitudes, signs and an
// L1 energy. Stage 2 picks a candidate symbol, debounces it with a dwell
// counter, applies move hysteresis and masks SELECT during a refractory
// window after SELECT is left. Two cycles from valid_in to valid_out,
// full-rate, no backpressure.
module boreal_symbolic_fsm #(
  parameter int W       = 24,
  parameter int DWELL   = 4,
  parameter int REFRACT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  boreal_symbolic_fsm_if.slave bus
);

  // A dwell of zero makes no sense; treat it as "commit on first sample".
  localparam int DWELL_EFF   = (DWELL < 1) ? 1 : DWELL;
  localparam int DW          = $clog2(DWELL_EFF + 1);
  localparam int REFRACT_EFF = (REFRACT < 0) ? 0 : REFRACT;
  localparam int RW          = (REFRACT_EFF > 0) ? $clog2(REFRACT_EFF + 1) : 1;

  localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_EFF - 1);
  localparam logic [RW-1:0] REFRACT_LOAD = RW'(REFRACT_EFF);

  // Symbol codes; 6 and 7 are never produced.
  localparam logic [2:0] SYM_IDLE   = 3'd0;
  localparam logic [2:0] SYM_X_POS  = 3'd1;
  localparam logic [2:0] SYM_X_NEG  = 3'd2;
  localparam logic [2:0] SYM_Y_POS  = 3'd3;
  localparam logic [2:0] SYM_Y_NEG  = 3'd4;
  localparam logic [2:0] SYM_SELECT = 3'd5;

  // ---------------------------------------------------------------------
  // Stage 1: magnitude / sign / energy
  // ---------------------------------------------------------------------
  // Index 0 is the x axis, index 1 the y axis.
  logic [W-1:0] raw_v [2];
  logic [W-1:0] abs_v [2];
  logic         sgn_v [2];

  assign raw_v[0] = bus.intent_x;
  assign raw_v[1] = bus.intent_y;

  // Two's-complement negate as an unsigned W-bit value: the most negative
  // input maps to 2^(W-1), which still fits, so no overflow handling.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    assign sgn_v[gi] = raw_v[gi][W-1];
    assign abs_v[gi] = raw_v[gi][W-1] ? ('0 - raw_v[gi]) : raw_v[gi];
  end

  logic         s1_valid_d, s1_valid_q;
  logic [W-1:0] ax_d, ax_q;
  logic [W-1:0] ay_d, ay_q;
  logic         sx_d, sx_q;
  logic         sy_d, sy_q;
  logic [W:0]   energy_d, energy_q;

  // Capture a new sample only when it is strobed; data holds otherwise.
  always_comb begin
    s1_valid_d = bus.valid_in;
    ax_d       = ax_q;
    ay_d       = ay_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    energy_d   = energy_q;
    if (bus.valid_in) begin
      ax_d     = abs_v[0];
      ay_d     = abs_v[1];
      sx_d     = sgn_v[0];
      sy_d     = sgn_v[1];
      energy_d = {1'b0, abs_v[0]} + {1'b0, abs_v[1]};
    end
  end

  // Stage 1 registers; reset drops any sample in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      ax_q       <= '0;
      ay_q       <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      energy_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      energy_q   <= energy_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: candidate selection
  // ---------------------------------------------------------------------
  logic [2:0]    state_d, state_q;
  logic [2:0]    pending_d, pending_q;
  logic [DW-1:0] dwell_d, dwell_q;
  logic [RW-1:0] refract_d, refract_q;
  logic          valid_out_d, valid_out_q;
  logic          change_d, change_q;
  logic          select_d, select_q;

  logic [2:0] cand;
  logic       sel_hit, x_hit, y_hit, x_hold, y_hold;

  // Priority: SELECT, dominant-axis move, hysteresis hold, IDLE.
  // Strict ax > ay / ay > ax means a tie never yields a fresh move.
  always_comb begin
    sel_hit = (energy_q > bus.thresh_select) && (refract_q == '0);
    x_hit   = (ax_q > bus.thresh_move) && (ax_q > ay_q);
    y_hit   = (ay_q > bus.thresh_move) && (ay_q > ax_q);
    x_hold  = (((state_q == SYM_X_POS) && !sx_q) ||
               ((state_q == SYM_X_NEG) &&  sx_q)) &&
              (ax_q > bus.thresh_hold);
    y_hold  = (((state_q == SYM_Y_POS) && !sy_q) ||
               ((state_q == SYM_Y_NEG) &&  sy_q)) &&
              (ay_q > bus.thresh_hold);
    cand    = SYM_IDLE;
    if (sel_hit) begin
      cand = SYM_SELECT;
    end else if (x_hit) begin
      cand = sx_q ? SYM_X_NEG : SYM_X_POS;
    end else if (y_hit) begin
      cand = sy_q ? SYM_Y_NEG : SYM_Y_POS;
    end else if (x_hold || y_hold) begin
      cand = state_q;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: dwell debounce, refractory window and result strobes
  // ---------------------------------------------------------------------
  // Everything here advances only on a valid stage-1 sample, so gaps in
  // the input stream neither age the dwell count nor the lockout.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    dwell_d     = dwell_q;
    refract_d   = refract_q;
    valid_out_d = s1_valid_q;
    change_d    = 1'b0;
    select_d    = 1'b0;
    if (s1_valid_q) begin
      if (cand == state_q) begin
        // Agreement with the committed symbol cancels any pending change.
        dwell_d   = '0;
        pending_d = state_q;
      end else if (cand == pending_q) begin
        // One more agreeing sample; commit when the count reaches DWELL.
        // Committing resets the count, so it can never run past DWELL.
        if (dwell_q >= DWELL_LAST) begin
          state_d = cand;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end else begin
        // New contender: this sample is its first vote.
        pending_d = cand;
        if (DWELL_EFF == 1) begin
          state_d = cand;
          dwell_d = '0;
        end else begin
          dwell_d = DW'(1);
        end
      end

      change_d = (state_d != state_q);
      select_d = change_d && (state_d == SYM_SELECT);

      // Leaving SELECT arms the lockout; later samples count it down.
      if ((state_q == SYM_SELECT) && (state_d != SYM_SELECT)) begin
        refract_d = REFRACT_LOAD;
      end else if (refract_q != '0) begin
        refract_d = refract_q - RW'(1);
      end
    end
  end

  // Stage 2 registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SYM_IDLE;
      pending_q   <= SYM_IDLE;
      dwell_q     <= '0;
      refract_q   <= '0;
      valid_out_q <= 1'b0;
      change_q    <= 1'b0;
      select_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      dwell_q     <= dwell_d;
      refract_q   <= refract_d;
      valid_out_q <= valid_out_d;
      change_q    <= change_d;
      select_q    <= select_d;
    end
  end

  assign bus.valid_out    = valid_out_q;
  assign bus.state_id     = state_q;
  assign bus.change_pulse = change_q;
  assign bus.select_event = select_q;

endmodule

// File: tb/tb_boreal_symbolic_fsm.sv
// Directed bench for boreal_symbolic_fsm with a scoreboard: an independent
// behavioural model predicts each result when the sample is driven, and the
// monitor pops and compares when valid_out appears.
module tb_boreal_symbolic_fsm;
  localparam int W       = 24;
  localparam int DWELL   = 4;
  localparam int REFRACT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_prev = 1'b1;
  always #5 clk = ~clk;

  boreal_symbolic_fsm_if #(.W(W)) bus ();

  boreal_symbolic_fsm #(.W(W), .DWELL(DWELL), .REFRACT(REFRACT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        chg;
    logic        sel;
    logic [31:0] stamp;
  } exp_t;

  exp_t        q[$];
  logic [2:0]  rec[$];
  logic [2:0]  rec_a[$];
  int          checks = 0;
  int          errors = 0;
  int          sel_cnt = 0;
  logic [31:0] cyc = 0;

  // Model state and thresholds
  int    m_state = 0, m_pend = 0, m_dwell = 0, m_ref = 0;
  longint tm = 100, th = 50, tsel = 1000;

  // Gap-invariance pattern
  longint pat_x [16] = '{200, 200, 200, 200, -300, -300, -300, 0,
                         0, 0, 0, 0, 0, 0, 0, 0};
  longint pat_y [16] = '{10, 10, 10, 10, 0, 0, 0, 0,
                         -250, -250, -250, -250, 0, 0, 0, 0};

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference behaviour for one valid sample.
  function automatic void model_push(input longint x, input longint y);
    longint ax, ay, en;
    int cand, old;
    exp_t e;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    en = ax + ay;
    if (en > tsel && m_ref == 0)            cand = 5;
    else if (ax > tm && ax > ay)            cand = (x < 0) ? 2 : 1;
    else if (ay > tm && ay > ax)            cand = (y < 0) ? 4 : 3;
    else if (m_state == 1 && x >= 0 && ax > th) cand = 1;
    else if (m_state == 2 && x <  0 && ax > th) cand = 2;
    else if (m_state == 3 && y >= 0 && ay > th) cand = 3;
    else if (m_state == 4 && y <  0 && ay > th) cand = 4;
    else                                    cand = 0;
    old = m_state;
    if (cand == m_state) begin
      m_dwell = 0;
      m_pend  = m_state;
    end else begin
      if (cand == m_pend) m_dwell++;
      else begin
        m_pend  = cand;
        m_dwell = 1;
      end
      if (m_dwell >= DWELL) begin
        m_state = cand;
        m_dwell = 0;
      end
    end
    if (old == 5 && m_state != 5) m_ref = REFRACT;
    else if (m_ref > 0)           m_ref--;
    e.st    = 3'(m_state);
    e.chg   = (m_state != old);
    e.sel   = (m_state != old) && (m_state == 5);
    e.stamp = cyc;
    q.push_back(e);
  endfunction

  task automatic send(input longint x, input longint y);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.intent_x = x[W-1:0];
    bus.intent_y = y[W-1:0];
    model_push(x, y);
  endtask

  task automatic send_n(input int n, input longint x, input longint y);
    for (int i = 0; i < n; i++) send(x, y);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.valid_in = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  task automatic set_thr(input longint m, input longint h, input longint s);
    tm = m; th = h; tsel = s;
    bus.thresh_move   = m[W-1:0];
    bus.thresh_hold   = h[W-1:0];
    bus.thresh_select = s[W:0];
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("drain_qsize", q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_state = 0; m_pend = 0; m_dwell = 0; m_ref = 0;
    for (int i = 0; i < n; i++) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: reset values while reset was sampled, scoreboard otherwise.
  always @(negedge clk) begin
    if (!rst_prev) begin
      check("rst_valid_out", bus.valid_out, 0);
      check("rst_state_id", bus.state_id, 0);
      check("rst_change", bus.change_pulse, 0);
      check("rst_select", bus.select_event, 0);
    end else if (bus.valid_out === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid_out", bus.valid_out, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_state_id", bus.state_id, e.st);
        check("out_change", bus.change_pulse, e.chg);
        check("out_select", bus.select_event, e.sel);
        check("out_latency", cyc - e.stamp, 2);
        rec.push_back(bus.state_id);
        if (bus.select_event) sel_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.intent_x = '0;
    bus.intent_y = '0;
    set_thr(100, 50, 1000);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset / idle
    send_n(5, 0, 0);
    drain();
    check("idle_state", bus.state_id, 0);

    // Dwell debounce
    send_n(3, 200, 10);
    send(0, 0);
    drain();
    check("dwell_short", bus.state_id, 0);
    send_n(4, 200, 10);
    drain();
    check("dwell_xpos", bus.state_id, 1);
    send_n(4, -200, 10);
    drain();
    check("dwell_xneg", bus.state_id, 2);

    // Hysteresis and ties
    send_n(4, 200, 0);
    drain();
    check("hyst_commit", bus.state_id, 1);
    send_n(10, 80, 0);
    drain();
    check("hyst_hold", bus.state_id, 1);
    send_n(4, 40, 0);
    drain();
    check("hyst_release", bus.state_id, 0);
    send_n(4, 150, 150);
    drain();
    check("tie_idle", bus.state_id, 0);

    // Select and refractory
    sel_cnt = 0;
    send_n(4, 600, 600);
    drain();
    check("select_commit", bus.state_id, 5);
    check("select_once", sel_cnt, 1);
    send_n(4, 0, 0);
    drain();
    check("select_leave", bus.state_id, 0);
    send_n(REFRACT, 600, 600);
    drain();
    check("refract_masked", bus.state_id, 0);
    send_n(4, 600, 600);
    drain();
    check("refract_expired", bus.state_id, 5);
    check("select_twice", sel_cnt, 2);

    // Extremes and strict thresholds
    set_thr(100, 50, (longint'(1) << (W + 1)) - 1);
    send_n(4, -(longint'(1) << (W - 1)), 0);
    drain();
    check("extreme_xneg", bus.state_id, 2);
    send_n(4, (longint'(1) << (W - 1)) - 1, -(longint'(1) << (W - 1)));
    drain();
    check("extreme_yneg", bus.state_id, 4);
    send_n(4, 0, 0);
    drain();
    check("extreme_idle", bus.state_id, 0);
    set_thr(100, 50, 1000);
    send_n(4, 100, 0);
    drain();
    check("move_strict", bus.state_id, 0);
    send_n(4, 101, 0);
    drain();
    check("move_above", bus.state_id, 1);
    send_n(4, 500, 500);
    drain();
    check("energy_strict", bus.state_id, 1);
    send_n(4, 500, 501);
    drain();
    check("energy_above", bus.state_id, 5);

    // Gap invariance: back-to-back vs one-in-three
    do_reset(1);
    rec.delete();
    for (int i = 0; i < 16; i++) send(pat_x[i], pat_y[i]);
    drain();
    rec_a = rec;
    do_reset(1);
    rec.delete();
    for (int i = 0; i < 16; i++) begin
      send(pat_x[i], pat_y[i]);
      idle(2);
    end
    drain();
    check("gap_count", rec.size(), rec_a.size());
    for (int i = 0; i < 16 && i < rec.size() && i < rec_a.size(); i++)
      check("gap_symbol", rec[i], rec_a[i]);

    // Reset mid-dwell
    do_reset(1);
    send_n(3, 200, 0);
    do_reset(1);
    send(200, 0);
    drain();
    check("mid_reset_nocommit", bus.state_id, 0);
    send_n(2, 200, 0);
    drain();
    check("mid_reset_restart", bus.state_id, 0);
    send(200, 0);
    drain();
    check("mid_reset_commit", bus.state_id, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
